// File: rtl/adc_scan_sequencer_pkg.sv
// Shared constants and types for the ADC scan sequencer.
package adc_pkg;

   localparam int NUM_CH       = 8;
   localparam int DATA_W       = 10;
   localparam int SEL_W        = 3;
   // adc_done is not trusted during the first cycles of a conversion (stale level from the reader)
   localparam int GUARD_CYCLES = 2;

   typedef enum logic [1:0] {
      S_IDLE        = 2'd0,
      S_CONVERT     = 2'd1,
      S_GAP         = 2'd2,
      S_WAIT_PERIOD = 2'd3
   } adc_seq_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/adc_scan_sequencer_next_ch.sv
// Finds the lowest set mask bit at or above a floor index.
// A floor of NUM_CH (one past the last channel) always reports not found.
module adc_next_ch
   import adc_pkg::*;
(
   input  logic [NUM_CH-1:0] i_mask,
   input  logic [SEL_W:0]    i_floor,
   output logic [SEL_W-1:0]  o_idx,
   output logic              o_found
);

   // Priority search from the top down so the lowest qualifying bit wins
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (i_mask[i] && (i >= int'(i_floor))) begin
            o_idx   = SEL_W'(i);
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scan sequencer for the SPI ADC reader: walks a channel mask in ascending
// order, captures each result into an 8-entry bank and paces repeated scans.
// Reader handshake: o_adc_enable is held high for the whole conversion with
// o_adc_sel stable; the first i_adc_done=1 seen after the stale-level guard
// ends the conversion, and enable then stays low for GAP_CYCLES cycles.
module adc_scan_sequencer
   import adc_pkg::*;
#(
   parameter int PERIOD_W       = 24,
   parameter int GAP_CYCLES     = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_start,
   input  logic                i_continuous,
   input  logic [NUM_CH-1:0]   i_ch_mask,
   input  logic [PERIOD_W-1:0] i_period,
   output logic                o_adc_enable,
   output logic [SEL_W-1:0]    o_adc_sel,
   input  logic                i_adc_done,
   input  logic [DATA_W-1:0]   i_adc_data,
   input  logic [SEL_W-1:0]    i_rd_ch,
   output logic [DATA_W-1:0]   o_rd_data,
   output logic [NUM_CH-1:0]   o_result_valid,
   output logic                o_busy,
   output logic                o_scan_done,
   output logic                o_timeout_err,
   output adc_seq_state_t      o_state
);

   // One shared counter serves the conversion timeout, the gap and the period wait
   localparam int CNT_W = max_int(PERIOD_W,
                                  max_int($clog2(TIMEOUT_CYCLES + 1), $clog2(GAP_CYCLES + 1)));

   adc_seq_state_t      r_state, w_state_nx;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nx, w_cnt_inc, w_period_ext;
   logic [SEL_W-1:0]    r_sel, w_sel_nx;
   logic                r_enable, w_enable_nx;
   logic [NUM_CH-1:0]   r_mask_q, w_mask_nx;
   logic [NUM_CH-1:0]   r_valid, w_valid_nx;
   logic                r_scan_done, w_scan_done_nx;
   logic                r_timeout_err, w_timeout_nx;
   logic                w_bank_we;
   logic                w_launch;
   logic [DATA_W-1:0]   r_bank [NUM_CH];
   logic [DATA_W-1:0]   r_rd_data;

   logic [SEL_W-1:0]    w_first_idx, w_adv_idx;
   logic                w_first_found, w_adv_found;
   logic [SEL_W:0]      w_adv_floor;

   // Lowest channel of the live mask, used whenever a new scan begins
   adc_next_ch u_first_ch (
      .i_mask  (i_ch_mask),
      .i_floor ('0),
      .o_idx   (w_first_idx),
      .o_found (w_first_found)
   );

   // Next channel above the current one in the latched mask; none after channel 7
   assign w_adv_floor = {1'b0, r_sel} + (SEL_W + 1)'(1);

   adc_next_ch u_adv_ch (
      .i_mask  (r_mask_q),
      .i_floor (w_adv_floor),
      .o_idx   (w_adv_idx),
      .o_found (w_adv_found)
   );

   assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
   assign w_period_ext = CNT_W'(i_period);

   // Next-state and datapath-control decode
   always_comb begin
      w_state_nx     = r_state;
      w_cnt_nx       = w_cnt_inc;
      w_sel_nx       = r_sel;
      w_enable_nx    = r_enable;
      w_mask_nx      = r_mask_q;
      w_valid_nx     = r_valid;
      w_scan_done_nx = 1'b0;
      w_timeout_nx   = r_timeout_err;
      w_bank_we      = 1'b0;
      w_launch       = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_cnt_nx = '0;
            if (i_start && w_first_found) begin
               w_launch   = 1'b1;
               w_valid_nx = '0;
            end
         end

         S_CONVERT: begin
            if ((r_cnt >= CNT_W'(GUARD_CYCLES)) && i_adc_done) begin
               w_bank_we         = 1'b1;
               w_valid_nx[r_sel] = 1'b1;
               w_enable_nx       = 1'b0;
               w_cnt_nx          = '0;
               w_state_nx        = S_GAP;
            end else if (r_cnt >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
               w_timeout_nx = 1'b1;
               w_enable_nx  = 1'b0;
               w_cnt_nx     = '0;
               w_state_nx   = S_GAP;
            end
         end

         S_GAP: begin
            if (r_cnt >= CNT_W'(GAP_CYCLES - 1)) begin
               w_cnt_nx = '0;
               if (w_adv_found) begin
                  w_sel_nx    = w_adv_idx;
                  w_enable_nx = 1'b1;
                  w_state_nx  = S_CONVERT;
               end else begin
                  w_scan_done_nx = 1'b1;
                  if (!i_continuous) begin
                     w_state_nx = S_IDLE;
                  end else if (i_period == '0) begin
                     w_launch = 1'b1;
                  end else begin
                     w_state_nx = S_WAIT_PERIOD;
                  end
               end
            end
         end

         S_WAIT_PERIOD: begin
            if (!i_continuous) begin
               w_cnt_nx   = '0;
               w_state_nx = S_IDLE;
            end else if ((w_period_ext == '0) || (r_cnt >= w_period_ext - 1'b1)) begin
               w_launch = 1'b1;
            end
         end

         default: begin
            w_state_nx = S_IDLE;
         end
      endcase

      // New scan: freshly sampled mask, first channel selected and enabled together
      if (w_launch) begin
         w_cnt_nx = '0;
         if (w_first_found) begin
            w_mask_nx   = i_ch_mask;
            w_sel_nx    = w_first_idx;
            w_enable_nx = 1'b1;
            w_state_nx  = S_CONVERT;
         end else begin
            w_enable_nx = 1'b0;
            w_state_nx  = S_IDLE;
         end
      end
   end

   // State and control registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_sel         <= '0;
         r_enable      <= 1'b0;
         r_mask_q      <= '0;
         r_valid       <= '0;
         r_scan_done   <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_cnt         <= w_cnt_nx;
         r_sel         <= w_sel_nx;
         r_enable      <= w_enable_nx;
         r_mask_q      <= w_mask_nx;
         r_valid       <= w_valid_nx;
         r_scan_done   <= w_scan_done_nx;
         r_timeout_err <= w_timeout_nx;
      end
   end

   // Result bank, written on the cycle the reader reports done
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_bank[i] <= '0;
         end
      end else if (w_bank_we) begin
         r_bank[r_sel] <= i_adc_data;
      end
   end

   // Registered read port; a same-cycle write is visible one cycle later
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= r_bank[i_rd_ch];
      end
   end

   assign o_adc_enable   = r_enable;
   assign o_adc_sel      = r_sel;
   assign o_rd_data      = r_rd_data;
   assign o_result_valid = r_valid;
   assign o_busy         = (r_state != S_IDLE);
   assign o_scan_done    = r_scan_done;
   assign o_timeout_err  = r_timeout_err;
   assign o_state        = r_state;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: a behavioural SPI reader, an event monitor and
// a scan-level reference model derived from the mask/timing rules.
module tb_adc_scan_sequencer;
   import adc_pkg::*;

   localparam int GAP = 64;
   localparam int TMO = 1024;
   localparam int PER = 100;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic                i_start      = 1'b0;
   logic                i_continuous = 1'b0;
   logic [7:0]          i_ch_mask    = '0;
   logic [23:0]         i_period     = '0;
   logic                i_adc_done   = 1'b0;
   logic [9:0]          i_adc_data   = '0;
   logic [2:0]          i_rd_ch      = '0;
   logic                o_adc_enable;
   logic [2:0]          o_adc_sel;
   logic [9:0]          o_rd_data;
   logic [7:0]          o_result_valid;
   logic                o_busy, o_scan_done, o_timeout_err;
   adc_seq_state_t      o_state;

   adc_scan_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .i_start        (i_start),
      .i_continuous   (i_continuous),
      .i_ch_mask      (i_ch_mask),
      .i_period       (i_period),
      .o_adc_enable   (o_adc_enable),
      .o_adc_sel      (o_adc_sel),
      .i_adc_done     (i_adc_done),
      .i_adc_data     (i_adc_data),
      .i_rd_ch        (i_rd_ch),
      .o_rd_data      (o_rd_data),
      .o_result_valid (o_result_valid),
      .o_busy         (o_busy),
      .o_scan_done    (o_scan_done),
      .o_timeout_err  (o_timeout_err),
      .o_state        (o_state)
   );

   // ---------------- reader model ----------------
   // Counts cycles of enable high; raises done with base+channel after rd_lat cycles.
   // In stale mode done stays high after enable falls and only clears 3 cycles
   // into the next conversion.
   int         rd_lat      = 20;
   logic [9:0] rd_base     = 10'h100;
   bit         rd_stale    = 1'b0;
   bit         rd_never_en = 1'b0;
   logic [2:0] rd_never_ch = '0;
   int         rd_cnt      = 0;

   always @(negedge clk) begin
      if (o_adc_enable) begin
         rd_cnt++;
         if (rd_stale && rd_cnt == 3) i_adc_done = 1'b0;
         if (rd_cnt == rd_lat && !(rd_never_en && o_adc_sel == rd_never_ch)) begin
            i_adc_done = 1'b1;
            i_adc_data = rd_base + 10'(o_adc_sel);
         end
      end else begin
         rd_cnt = 0;
         if (!rd_stale) i_adc_done = 1'b0;
      end
   end

   // ---------------- event monitor ----------------
   int   cyc = 0;
   logic prev_en = 1'b0;
   logic [2:0] prev_sel = '0;
   bit   grab_next = 1'b0;
   int   sel_glitch = 0;
   int   rise_q[$], fall_q[$], done_q[$], sel_q[$], rd_fall_q[$], rd_next_q[$];

   always @(negedge clk) begin
      cyc++;
      if (grab_next) begin
         rd_next_q.push_back(int'(o_rd_data));
         grab_next = 1'b0;
      end
      if (o_adc_enable && !prev_en) begin
         rise_q.push_back(cyc);
         sel_q.push_back(int'(o_adc_sel));
      end
      if (o_adc_enable && prev_en && o_adc_sel != prev_sel) sel_glitch++;
      if (!o_adc_enable && prev_en) begin
         fall_q.push_back(cyc);
         rd_fall_q.push_back(int'(o_rd_data));
         grab_next = 1'b1;
      end
      if (o_scan_done) done_q.push_back(cyc);
      prev_en  = o_adc_enable;
      prev_sel = o_adc_sel;
   end

   // ---------------- scoreboard ----------------
   int         errors = 0;
   int         checks = 0;
   logic [2:0] exp_q[$];
   logic [9:0] exp_bank[8];
   logic [7:0] exp_valid = '0;
   logic       exp_to    = 1'b0;
   logic [7:0] t_mask;
   int         t_lat;
   logic [9:0] t_base, t_old;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int qat(input int q[$], input int idx);
      if (idx < q.size()) return q[idx];
      return -1;
   endfunction

   task automatic clear_logs();
      rise_q.delete(); fall_q.delete(); done_q.delete(); sel_q.delete();
      rd_fall_q.delete(); rd_next_q.delete();
      sel_glitch = 0;
   endtask

   task automatic wait_done(input int n, input int budget, input string tag);
      int k = 0;
      while (done_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(done_q.size() >= n), 32'd1);
   endtask

   task automatic wait_rise(input int n, input int budget, input string tag);
      int k = 0;
      while (rise_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(rise_q.size() >= n), 32'd1);
   endtask

   task automatic pulse_start(input logic [7:0] mask);
      @(negedge clk);
      i_ch_mask = mask;
      i_start   = 1'b1;
      @(negedge clk);
      i_start   = 1'b0;
   endtask

   task automatic check_bank(input string tag);
      for (int ch = 0; ch < 8; ch++) begin
         @(negedge clk);
         i_rd_ch = 3'(ch);
         @(negedge clk);
         check($sformatf("%s_bank%0d", tag, ch), 32'(o_rd_data), 32'(exp_bank[ch]));
      end
   endtask

   // One non-continuous scan, checked against the mask-walk model
   task automatic run_scan(input logic [7:0] mask, input int lat, input logic [9:0] base,
                           input bit stale, input bit never_en, input logic [2:0] never_ch,
                           input string tag);
      int         n, dur_exp;
      logic [2:0] ch;
      bit         to;
      rd_lat = lat; rd_base = base; rd_stale = stale;
      rd_never_en = never_en; rd_never_ch = never_ch;
      clear_logs();
      pulse_start(mask);
      wait_rise(1, 100, {tag, "_first_rise"});
      // a second start with a different mask while busy must change nothing
      i_ch_mask = ~mask;
      i_start   = 1'b1;
      @(negedge clk);
      i_start   = 1'b0;
      wait_done(1, 20000, {tag, "_scan_done_wait"});
      repeat (2) @(negedge clk);

      exp_q.delete();
      for (int c = 0; c < 8; c++) if (mask[c]) exp_q.push_back(3'(c));
      exp_valid = '0;
      n = exp_q.size();
      check({tag, "_nconv"}, 32'(sel_q.size()), 32'(n));
      for (int k = 0; k < n; k++) begin
         ch      = exp_q[k];
         to      = never_en && (ch == never_ch);
         dur_exp = to ? TMO : lat;
         check($sformatf("%s_sel%0d", tag, k), 32'(qat(sel_q, k)), 32'(ch));
         check($sformatf("%s_en_high%0d", tag, k), 32'(qat(fall_q, k) - qat(rise_q, k)), 32'(dur_exp));
         if (k > 0)
            check($sformatf("%s_gap%0d", tag, k), 32'(qat(rise_q, k) - qat(fall_q, k - 1)), 32'(GAP));
         if (to) exp_to = 1'b1;
         else begin
            exp_bank[ch]  = base + 10'(ch);
            exp_valid[ch] = 1'b1;
         end
      end
      check({tag, "_ndone"}, 32'(done_q.size()), 32'd1);
      check({tag, "_done_time"}, 32'(qat(done_q, 0)), 32'(qat(fall_q, n - 1) + GAP));
      check({tag, "_busy_after"}, 32'(o_busy), 32'd0);
      check({tag, "_sel_stable"}, 32'(sel_glitch), 32'd0);
      check({tag, "_valid"}, 32'(o_result_valid), 32'(exp_valid));
      check({tag, "_timeout"}, 32'(o_timeout_err), 32'(exp_to));
      check_bank(tag);
   endtask

   // ---------------- directed sequence ----------------
   int bad;

   initial begin
      for (int c = 0; c < 8; c++) exp_bank[c] = '0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_enable", 32'(o_adc_enable), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_outputs", 32'({o_adc_sel, o_rd_data, o_result_valid, o_scan_done, o_timeout_err}), 32'd0);
      check("rst_state", 32'(o_state), 32'(S_IDLE));

      // directed: mask A4, 20-cycle reader, rd_ch parked on channel 7
      i_rd_ch = 3'd7;
      t_old   = exp_bank[7];
      run_scan(8'hA4, 20, 10'h100, 1'b0, 1'b0, 3'd0, "a4");
      check("a4_valid_const", 32'(o_result_valid), 32'h0000_00A4);
      check("a4_rd_same_cycle_old", 32'(qat(rd_fall_q, 2)), 32'(t_old));
      check("a4_rd_next_cycle_new", 32'(qat(rd_next_q, 2)), 32'h107);

      // start with an empty mask does nothing
      clear_logs();
      pulse_start(8'h00);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (o_busy || o_adc_enable) bad++;
      end
      check("mask0_quiet", 32'(bad), 32'd0);

      // channel 3 never answers
      run_scan(8'h08, 20, 10'h155, 1'b0, 1'b1, 3'd3, "tmo");

      // random masks, latencies and data
      for (int r = 0; r < 4; r++) begin
         t_mask = 8'($urandom_range(1, 255));
         t_lat  = $urandom_range(3, 40);
         t_base = 10'($urandom);
         run_scan(t_mask, t_lat, t_base, 1'b0, 1'b0, 3'd0, $sformatf("rnd%0d", r));
      end

      // done left high across the gap must not be taken as the next result
      t_mask = 8'($urandom_range(1, 255)) | 8'h11;
      t_lat  = $urandom_range(3, 30);
      t_base = 10'($urandom);
      run_scan(t_mask, t_lat, t_base, 1'b1, 1'b0, 3'd0, "stale");
      rd_stale = 1'b0;
      repeat (2) @(negedge clk);

      // continuous with period 0: next scan starts straight from the gap on a fresh mask
      t_lat  = $urandom_range(3, 40);
      rd_lat = t_lat; rd_base = 10'h2A0; rd_never_en = 1'b0;
      clear_logs();
      i_continuous = 1'b1;
      i_period     = '0;
      pulse_start(8'h02);
      wait_rise(1, 100, "p0_rise1");
      i_ch_mask = 8'h40;
      wait_rise(2, 500, "p0_rise2");
      i_continuous = 1'b0;
      wait_done(2, 500, "p0_done_wait");
      repeat (2) @(negedge clk);
      check("p0_nconv", 32'(sel_q.size()), 32'd2);
      check("p0_sel0", 32'(qat(sel_q, 0)), 32'd1);
      check("p0_sel1", 32'(qat(sel_q, 1)), 32'd6);
      check("p0_interval", 32'(qat(done_q, 1) - qat(done_q, 0)), 32'(t_lat + GAP));
      exp_bank[1] = 10'h2A0 + 10'd1;
      exp_bank[6] = 10'h2A0 + 10'd6;
      check("p0_valid_kept", 32'(o_result_valid), 32'h42);
      check("p0_busy_after", 32'(o_busy), 32'd0);

      // continuous with period 100: constant scan-to-scan interval
      rd_lat = 20; rd_base = 10'h300;
      clear_logs();
      i_continuous = 1'b1;
      i_period     = 24'(PER);
      pulse_start(8'h01);
      wait_done(3, 2000, "cont_done_wait");
      check("cont_interval1", 32'(qat(done_q, 1) - qat(done_q, 0)), 32'(20 + GAP + PER));
      check("cont_interval2", 32'(qat(done_q, 2) - qat(done_q, 1)), 32'(20 + GAP + PER));
      repeat (3) @(negedge clk);
      check("cont_in_wait", 32'(o_state), 32'(S_WAIT_PERIOD));
      i_continuous = 1'b0;
      @(negedge clk);
      check("cont_stop_idle", 32'(o_state), 32'(S_IDLE));
      check("cont_stop_busy", 32'(o_busy), 32'd0);
      exp_bank[0] = 10'h300;
      check("cont_valid", 32'(o_result_valid), 32'h01);
      check_bank("cont");

      // reset during the second conversion of a scan
      rd_lat = 40;
      clear_logs();
      pulse_start(8'h30);
      wait_rise(2, 500, "rst_mid_rise");
      repeat (5) @(negedge clk);
      check("pre_rst_enable", 32'(o_adc_enable), 32'd1);
      check("pre_rst_valid", 32'(o_result_valid), 32'h10);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_enable", 32'(o_adc_enable), 32'd0);
      check("mid_rst_valid", 32'(o_result_valid), 32'd0);
      check("mid_rst_timeout", 32'(o_timeout_err), 32'd0);
      check("mid_rst_busy", 32'(o_busy), 32'd0);
      reset = 1'b0;
      for (int c = 0; c < 8; c++) exp_bank[c] = '0;
      check_bank("mid_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
